// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, request/writeback structs
// Imported by the registered ALU and by alu_issue_seq.
package alu_pkg;

  localparam int ALU_W   = 32;
  localparam int SHAMT_W = 5;
  localparam int OP_W    = 4;

  localparam logic [OP_W-1:0] ALUOP_ADD   = 4'h0;
  localparam logic [OP_W-1:0] ALUOP_SUB   = 4'h1;
  localparam logic [OP_W-1:0] ALUOP_AND   = 4'h2;
  localparam logic [OP_W-1:0] ALUOP_OR    = 4'h3;
  localparam logic [OP_W-1:0] ALUOP_XOR   = 4'h4;
  localparam logic [OP_W-1:0] ALUOP_SLL   = 4'h5;
  localparam logic [OP_W-1:0] ALUOP_SRL   = 4'h6;
  localparam logic [OP_W-1:0] ALUOP_SRA   = 4'h7;
  localparam logic [OP_W-1:0] ALUOP_SLT   = 4'h8;
  localparam logic [OP_W-1:0] ALUOP_SLTU  = 4'h9;
  localparam logic [OP_W-1:0] ALUOP_BSET  = 4'hA;
  localparam logic [OP_W-1:0] ALUOP_BCLR  = 4'hB;
  localparam logic [OP_W-1:0] ALUOP_BEXT  = 4'hC;
  localparam logic [OP_W-1:0] ALUOP_PASSB = 4'hD;

  typedef struct packed {
    logic [OP_W-1:0]    opcode;
    logic [ALU_W-1:0]   wordA;
    logic [ALU_W-1:0]   wordB;
    logic [SHAMT_W-1:0] shamt;
  } alu_req_t;

  typedef struct packed {
    logic [ALU_W-1:0] result;
    logic             flag_equal;
    logic             flag_notequal;
  } alu_wb_t;

  // Idle drive: ADD of zeros, whose ALU output nobody consumes.
  function automatic alu_req_t alu_idle_req();
    alu_req_t r;
    r.opcode = ALUOP_ADD;
    r.wordA  = '0;
    r.wordB  = '0;
    r.shamt  = '0;
    return r;
  endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// rtl/alu_seq_fifo.sv - result FIFO for alu_issue_seq
// Power-of-two depth, storage zeroed on reset, head read from rd_ptr.
module alu_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_push_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_head,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign do_pop  = i_pop && (count_q != '0);
  assign do_push = i_push && ((count_q != CNT_FULL) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= i_push_data;
    end
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_count = count_q;

endmodule

// File: rtl/alu_issue_seq.sv
// rtl/alu_issue_seq.sv - ALU request sequencer with in-flight tag and result FIFO
// Optional per-entry flag storage under ALU_SEQ_FLAGS_EN.
module alu_issue_seq
  import alu_pkg::*;
#(
  parameter int TAG_W = 5,
  parameter int DEPTH = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_req_valid,
  output logic                o_req_ready,
  input  logic [3:0]          i_req_opcode,
  input  logic [31:0]         i_req_wordA,
  input  logic [31:0]         i_req_wordB,
  input  logic [4:0]          i_req_shamt,
  input  logic [TAG_W-1:0]    i_req_tag,
  output logic [3:0]          o_alu_opcode,
  output logic [31:0]         o_alu_wordA,
  output logic [31:0]         o_alu_wordB,
  output logic [4:0]          o_alu_shamt,
  input  logic [31:0]         i_alu_result,
  input  logic                i_alu_flag_equal,
  input  logic                i_alu_flag_notequal,
  output logic                o_wb_valid,
  input  logic                i_wb_ready,
  output logic [31:0]         o_wb_result,
  output logic [TAG_W-1:0]    o_wb_tag,
  output logic                o_wb_flag_equal,
  output logic                o_wb_flag_notequal
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

  alu_req_t         req_in, alu_drive;
  logic             accept;
  logic             inflight_v_q, inflight_v_d;
  logic [TAG_W-1:0] inflight_tag_q, inflight_tag_d;
  logic [CW-1:0]    fifo_count;
  logic [CW:0]      credit_used;

  assign req_in.opcode = i_req_opcode;
  assign req_in.wordA  = i_req_wordA;
  assign req_in.wordB  = i_req_wordB;
  assign req_in.shamt  = i_req_shamt;

  // Stored entries plus the one the ALU is computing must fit in the FIFO.
  assign credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_v_q};
  assign o_req_ready = credit_used < CREDITS;
  assign accept      = i_req_valid && o_req_ready;

  always_comb begin
    alu_drive = alu_idle_req();
    if (accept) alu_drive = req_in;
  end

  assign o_alu_opcode = alu_drive.opcode;
  assign o_alu_wordA  = alu_drive.wordA;
  assign o_alu_wordB  = alu_drive.wordB;
  assign o_alu_shamt  = alu_drive.shamt;

  always_comb begin
    inflight_v_d   = accept;
    inflight_tag_d = accept ? i_req_tag : inflight_tag_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inflight_v_q   <= 1'b0;
      inflight_tag_q <= '0;
    end else begin
      inflight_v_q   <= inflight_v_d;
      inflight_tag_q <= inflight_tag_d;
    end
  end

`ifdef ALU_SEQ_FLAGS_EN
  localparam int EW = TAG_W + $bits(alu_wb_t);

  alu_wb_t wb_cap, wb_head;

  assign wb_cap.result        = i_alu_result;
  assign wb_cap.flag_equal    = i_alu_flag_equal;
  assign wb_cap.flag_notequal = i_alu_flag_notequal;
`else
  localparam int EW = TAG_W + 32;

  logic unused_alu_flags;
  assign unused_alu_flags = i_alu_flag_equal ^ i_alu_flag_notequal;
`endif

  logic [EW-1:0] push_data, head;

`ifdef ALU_SEQ_FLAGS_EN
  assign push_data          = {inflight_tag_q, wb_cap};
  assign wb_head            = head[$bits(alu_wb_t)-1:0];
  assign o_wb_result        = wb_head.result;
  assign o_wb_flag_equal    = wb_head.flag_equal;
  assign o_wb_flag_notequal = wb_head.flag_notequal;
`else
  assign push_data          = {inflight_tag_q, i_alu_result};
  assign o_wb_result        = head[31:0];
  assign o_wb_flag_equal    = 1'b0;
  assign o_wb_flag_notequal = 1'b0;
`endif

  assign o_wb_tag   = head[EW-1 -: TAG_W];
  assign o_wb_valid = (fifo_count != '0);

  alu_seq_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (inflight_v_q),
    .i_push_data (push_data),
    .i_pop       (i_wb_ready),
    .o_head      (head),
    .o_count     (fifo_count)
  );

endmodule

// File: tb/tb_alu_issue_seq.sv
// tb/tb_alu_issue_seq.sv - directed self-checking bench for alu_issue_seq
// Expected flag outputs follow ALU_SEQ_FLAGS_EN.
module tb_alu_issue_seq;
  import alu_pkg::*;

  localparam int TAG_W = 5;
  localparam int DEPTH = 4;
`ifdef ALU_SEQ_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic             clk, rst_n;
  logic             req_valid, req_ready;
  logic [3:0]       req_opcode;
  logic [31:0]      req_a, req_b;
  logic [4:0]       req_shamt;
  logic [TAG_W-1:0] req_tag;
  logic [3:0]       alu_opcode;
  logic [31:0]      alu_a, alu_b;
  logic [4:0]       alu_shamt;
  logic [31:0]      alu_result;
  logic             alu_eq, alu_ne;
  logic             wb_valid, wb_ready;
  logic [31:0]      wb_result;
  logic [TAG_W-1:0] wb_tag;
  logic             wb_eq, wb_ne;

  int checks = 0;
  int errors = 0;

  alu_issue_seq #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_req_valid         (req_valid),
    .o_req_ready         (req_ready),
    .i_req_opcode        (req_opcode),
    .i_req_wordA         (req_a),
    .i_req_wordB         (req_b),
    .i_req_shamt         (req_shamt),
    .i_req_tag           (req_tag),
    .o_alu_opcode        (alu_opcode),
    .o_alu_wordA         (alu_a),
    .o_alu_wordB         (alu_b),
    .o_alu_shamt         (alu_shamt),
    .i_alu_result        (alu_result),
    .i_alu_flag_equal    (alu_eq),
    .i_alu_flag_notequal (alu_ne),
    .o_wb_valid          (wb_valid),
    .i_wb_ready          (wb_ready),
    .o_wb_result         (wb_result),
    .o_wb_tag            (wb_tag),
    .o_wb_flag_equal     (wb_eq),
    .o_wb_flag_notequal  (wb_ne)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ALU stand-in with one-cycle latency.
  always_ff @(posedge clk) begin
    case (alu_opcode)
      ALUOP_ADD: alu_result <= alu_a + alu_b;
      ALUOP_SUB: alu_result <= alu_a - alu_b;
      ALUOP_SLL: alu_result <= alu_a << alu_shamt;
      ALUOP_SRA: alu_result <= $unsigned($signed(alu_a) >>> alu_shamt);
      default:   alu_result <= alu_a;
    endcase
    alu_eq <= (alu_a == alu_b);
    alu_ne <= (alu_a != alu_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh, input logic [TAG_W-1:0] tag);
    req_valid  = v;
    req_opcode = op;
    req_a      = a;
    req_b      = b;
    req_shamt  = sh;
    req_tag    = tag;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    wb_ready = 1'b0;
    drive(1'b0, ALUOP_ADD, 32'h0, 32'h0, 5'd0, '0);
    #2;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", req_ready); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
    checks++; if (wb_result !== 32'h0) begin errors++; $display("FAIL reset_wb_result got %h exp 0", wb_result); end
    checks++; if (wb_tag !== 5'd0) begin errors++; $display("FAIL reset_wb_tag got %h exp 0", wb_tag); end
    checks++; if ({wb_eq, wb_ne} !== 2'b00) begin errors++; $display("FAIL reset_wb_flags got %b exp 00", {wb_eq, wb_ne}); end
    checks++; if ({alu_opcode, alu_a, alu_b, alu_shamt} !== 73'h0) begin errors++; $display("FAIL reset_alu_drive got %h exp 0", {alu_opcode, alu_a, alu_b, alu_shamt}); end
    #1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_add();
    wb_ready = 1'b0;
    tick();
    drive(1'b1, ALUOP_ADD, 32'h5, 32'h3, 5'd0, 5'd7);
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL add_ready got %b exp 1", req_ready); end
    checks++; if ({alu_opcode, alu_a, alu_b} !== {ALUOP_ADD, 32'h5, 32'h3}) begin errors++; $display("FAIL add_passthru got %h exp %h", {alu_opcode, alu_a, alu_b}, {ALUOP_ADD, 32'h5, 32'h3}); end
    tick();
    drive(1'b0, ALUOP_SUB, 32'hDEAD, 32'hBEEF, 5'd3, 5'd1);
    #1;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL add_n1_valid got %b exp 0", wb_valid); end
    checks++; if ({alu_opcode, alu_a, alu_b, alu_shamt} !== 73'h0) begin errors++; $display("FAIL add_idle_drive got %h exp 0", {alu_opcode, alu_a, alu_b, alu_shamt}); end
    tick();
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL add_n2_valid got %b exp 1", wb_valid); end
    checks++; if (wb_result !== 32'h0000_0008) begin errors++; $display("FAIL add_result got %h exp 00000008", wb_result); end
    checks++; if (wb_tag !== 5'd7) begin errors++; $display("FAIL add_tag got %0d exp 7", wb_tag); end
    checks++; if ({wb_eq, wb_ne} !== {1'b0, FLAGS}) begin errors++; $display("FAIL add_flags got %b exp %b", {wb_eq, wb_ne}, {1'b0, FLAGS}); end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL add_popped got %b exp 0", wb_valid); end
  endtask

  task automatic test_back_to_back();
    wb_ready = 1'b1;
    tick();
    drive(1'b1, ALUOP_SUB, 32'd10, 32'd10, 5'd0, 5'd1);
    tick();
    drive(1'b1, ALUOP_SLL, 32'h1, 32'h0, 5'd31, 5'd2);
    tick();
    drive(1'b1, ALUOP_SRA, 32'h8000_0000, 32'h0, 5'd4, 5'd3);
    #1;
    checks++; if ({wb_valid, wb_tag, wb_result} !== {1'b1, 5'd1, 32'h0}) begin errors++; $display("FAIL b2b_sub got %h exp %h", {wb_valid, wb_tag, wb_result}, {1'b1, 5'd1, 32'h0}); end
    checks++; if ({wb_eq, wb_ne} !== {FLAGS, 1'b0}) begin errors++; $display("FAIL b2b_sub_flags got %b exp %b", {wb_eq, wb_ne}, {FLAGS, 1'b0}); end
    tick();
    drive(1'b0, ALUOP_ADD, 32'h0, 32'h0, 5'd0, 5'd0);
    #1;
    checks++; if ({wb_valid, wb_tag, wb_result} !== {1'b1, 5'd2, 32'h8000_0000}) begin errors++; $display("FAIL b2b_sll got %h exp %h", {wb_valid, wb_tag, wb_result}, {1'b1, 5'd2, 32'h8000_0000}); end
    tick();
    checks++; if ({wb_valid, wb_tag, wb_result} !== {1'b1, 5'd3, 32'hF800_0000}) begin errors++; $display("FAIL b2b_sra got %h exp %h", {wb_valid, wb_tag, wb_result}, {1'b1, 5'd3, 32'hF800_0000}); end
    tick();
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %b exp 0", wb_valid); end
    wb_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int acc = 0;
    wb_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      drive(1'b1, ALUOP_ADD, 32'(i), 32'd100, 5'd0, 5'(10 + i));
      #1;
      if (i == 4) begin
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_full_boundary got %b exp 0", req_ready); end
      end
      if (req_ready) acc++;
    end
    tick();
    drive(1'b0, ALUOP_ADD, 32'h0, 32'h0, 5'd0, 5'd0);
    checks++; if (acc != 4) begin errors++; $display("FAIL bp_accepted got %0d exp 4", acc); end
    wb_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({wb_valid, wb_tag, wb_result} !== {1'b1, 5'(10 + k), 32'(100 + k)}) begin
        errors++; $display("FAIL bp_drain_%0d got %h exp %h", k, {wb_valid, wb_tag, wb_result}, {1'b1, 5'(10 + k), 32'(100 + k)});
      end
      tick();
    end
    checks++; if ({wb_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL bp_after_drain got %b exp 01", {wb_valid, req_ready}); end
    wb_ready = 1'b0;
  endtask

  task automatic test_push_pop();
    int n = 0;
    wb_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      drive(1'b1, ALUOP_ADD, 32'h1000 + 32'(n), 32'h0, 5'd0, 5'(n));
      n++;
    end
    for (int j = 0; j < 10; j++) begin
      tick();
      wb_ready = 1'b1;
      drive(1'b1, ALUOP_ADD, 32'h1000 + 32'(n), 32'h0, 5'd0, 5'(n));
      n++;
      #1;
      checks++;
      if ({wb_valid, req_ready, wb_tag, wb_result} !== {2'b11, 5'(j), 32'h1000 + 32'(j)}) begin
        errors++; $display("FAIL pp_cycle_%0d got %h exp %h", j, {wb_valid, req_ready, wb_tag, wb_result}, {2'b11, 5'(j), 32'h1000 + 32'(j)});
      end
    end
    tick();
    drive(1'b0, ALUOP_ADD, 32'h0, 32'h0, 5'd0, 5'd0);
    for (int k = 10; k < 13; k++) begin
      #1;
      checks++;
      if ({wb_valid, wb_tag, wb_result} !== {1'b1, 5'(k), 32'h1000 + 32'(k)}) begin
        errors++; $display("FAIL pp_drain_%0d got %h exp %h", k, {wb_valid, wb_tag, wb_result}, {1'b1, 5'(k), 32'h1000 + 32'(k)});
      end
      tick();
    end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL pp_empty got %b exp 0", wb_valid); end
    wb_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    wb_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      drive(1'b1, ALUOP_ADD, 32'h55, 32'(c), 5'd0, 5'(20 + c));
    end
    tick();
    drive(1'b0, ALUOP_ADD, 32'h0, 32'h0, 5'd0, 5'd0);
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid got %b exp 1", wb_valid); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if ({wb_valid, req_ready} !== 2'b01) begin errors++; $display("FAIL rm_async got %b exp 01", {wb_valid, req_ready}); end
    checks++; if ({wb_tag, wb_result} !== 37'h0) begin errors++; $display("FAIL rm_zeroed got %h exp 0", {wb_tag, wb_result}); end
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rm_stale_%0d got %b exp 0", c, wb_valid); end
    end
    drive(1'b1, ALUOP_ADD, 32'h11, 32'h22, 5'd0, 5'd3);
    tick();
    drive(1'b0, ALUOP_ADD, 32'h0, 32'h0, 5'd0, 5'd0);
    tick();
    checks++; if ({wb_valid, wb_tag, wb_result} !== {1'b1, 5'd3, 32'h33}) begin errors++; $display("FAIL rm_fresh got %h exp %h", {wb_valid, wb_tag, wb_result}, {1'b1, 5'd3, 32'h33}); end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
  endtask

  task automatic test_flags_build();
    wb_ready = 1'b1;
    tick();
    drive(1'b1, ALUOP_SUB, 32'd10, 32'd10, 5'd0, 5'd9);
    tick();
    drive(1'b0, ALUOP_ADD, 32'h0, 32'h0, 5'd0, 5'd0);
    tick();
    checks++; if ({wb_valid, wb_tag, wb_result} !== {1'b1, 5'd9, 32'h0}) begin errors++; $display("FAIL fl_result got %h exp %h", {wb_valid, wb_tag, wb_result}, {1'b1, 5'd9, 32'h0}); end
    checks++; if ({wb_eq, wb_ne} !== {FLAGS, 1'b0}) begin errors++; $display("FAIL fl_flags got %b exp %b", {wb_eq, wb_ne}, {FLAGS, 1'b0}); end
    tick();
    wb_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_backpressure();
    test_push_pop();
    test_reset_mid();
    test_flags_build();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_seq.md
# alu_issue_seq

Request-side sequencer for the registered ALU: accepts operation requests over a valid/ready handshake, drives the ALU operand/opcode inputs, tracks the ALU's one-cycle registered latency with an in-flight tag, and captures result plus equal/not-equal flags into a small result FIFO. The FIFO feeds a valid/ready writeback port. Sits between the decode/issue stage and register-file writeback. It is the initiator and consumer on the ALU's opcode/operand-in, result/flags-out interface.

## Interface
- TAG_W, 5: width of destination tag carried alongside each request.
- DEPTH, 4: result FIFO entries; power of two, ≥2.
- i_clk  in  1  sole clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  request accepted when valid & ready.
- i_req_opcode  in  4  ALUOP_* code.
- i_req_wordA / i_req_wordB  in  32  operands.
- i_req_shamt  in  5  immediate shift amount / bit index.
- i_req_tag  in  TAG_W  destination tag.
- o_alu_opcode  out  4  to ALU.
- o_alu_wordA / o_alu_wordB  out  32  to ALU.
- o_alu_shamt  out  5  to ALU.
- i_alu_result  in  32  ALU registered result.
- i_alu_flag_equal / i_alu_flag_notequal  in  1  ALU registered flags.
- o_wb_valid  out  1  FIFO head valid.
- i_wb_ready  in  1  consumer takes head when valid & ready.
- o_wb_result  out  32  head result.
- o_wb_tag  out  TAG_W  head tag.
- o_wb_flag_equal / o_wb_flag_notequal  out  1  head flags.

## Operation
- Accept (cycle N): i_req_valid & o_req_ready. ALU inputs are combinational pass-through of i_req_* in cycle N. The ALU registers its result at the edge ending N.
- Idle drive: when no accept, o_alu_* = 0 (opcode ADD). The resulting ALU output is ignored.
- In-flight register: inflight_v/inflight_tag are set at the edge ending N. In cycle N+1, i_alu_result and the flags are valid. They are written to the FIFO with inflight_tag at the edge ending N+1.
- Credit rule: o_req_ready = (count + inflight_v) < DEPTH, combinational from registered state only. A result is never dropped.
- FIFO: wr_ptr/rd_ptr are log2(DEPTH) bits, wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pop when empty is impossible, because o_wb_valid = (count != 0).
- Head outputs come from the storage entry at rd_ptr. They are stable while o_wb_valid & !i_wb_ready.
- Back-to-back accepts are allowed every cycle while credit remains. Throughput is 1/cycle.
- Reset mid-operation clears inflight_v, count, and the pointers. Any in-flight ALU result is discarded.

## Timing
- Accept to o_wb_valid: 2 cycles (accept in N, o_wb_valid high in N+2 if the FIFO was empty).
- Pop to credit return: o_req_ready may rise in the cycle after the popping edge.
- Reset values: o_req_ready=1 (DEPTH≥2), o_wb_valid=0, o_wb_result=0, o_wb_tag=0, o_wb_flag_*=0, o_alu_*=0. FIFO storage is zeroed on reset.
- Full boundary: with count=DEPTH-1 and inflight_v=1, o_req_ready=0.
- Ordering: results leave strictly in accept order.

## Configuration
- ALU_SEQ_FLAGS_EN defined:
  - Flags are stored per FIFO entry.
  - o_wb_flag_equal/notequal reflect the ALU flags of that operation.
- ALU_SEQ_FLAGS_EN undefined:
  - No flag storage.
  - o_wb_flag_* tied 0.
  - i_alu_flag_* ignored.

## Structure
- Shared package alu_pkg holds:
  - the ALUOP_* constants (4-bit);
  - struct alu_req_t {opcode, wordA, wordB, shamt};
  - struct alu_wb_t {result, flag_equal, flag_notequal}.
- The ALU and this block both import alu_pkg.
- One sub-module, alu_seq_fifo: parameterised by DEPTH and entry width; synchronous push/pop; exposes count.
- The sequencer top holds the in-flight register and the credit logic.

## Test plan
- Single ADD: A=0x0000_0005, B=0x0000_0003, tag=7 accepted in cycle 1. Expect o_wb_valid in cycle 3 with result=0x0000_0008, tag=7, equal=0, notequal=1.
- Back-to-back with wb_ready=1, three requests in consecutive cycles:
  - SUB 10-10, expect result 0, equal=1;
  - SLL A=1, shamt=31, expect 0x8000_0000;
  - SRA A=0x8000_0000, shamt=4, expect 0xF800_0000.
  - All three emerge in consecutive cycles in order.
- Backpressure: hold i_wb_ready=0 and stream requests.
  - o_req_ready drops once 3 entries are stored plus 1 in flight (DEPTH=4). Exactly 4 requests are accepted.
  - Release i_wb_ready: all 4 drain in order, then ready returns.
- Simultaneous push and pop at count=2 for 10 cycles: count stays 2, and the pointers wrap correctly past DEPTH-1→0.
- Reset mid-stream: assert i_rst_n=0 with 2 entries queued and 1 in flight. Expect o_wb_valid=0 immediately (async), and no stale result after release.
- Build without ALU_SEQ_FLAGS_EN: repeat the SUB 10-10 case. Expect o_wb_flag_equal=0, and the result/tag unaffected.
